// File: rtl/stlb_ctrl.sv
// stlb_ctrl: one-at-a-time lookup sequencer for the STLB way arrays with
// per-set tree-PLRU replacement, page-walk fill on miss and a flush sweep.
//
// state  | meaning
// IDLE   | accept a lookup, or start a pending flush sweep
// LOOKUP | one-cycle arr_rd_en strobe
// CHECK  | sample arr_hit; hit -> RESP, miss -> WALK
// WALK   | walk_req_valid held until the walker accepts
// WAIT   | wait for walk_rsp_valid
// FILL   | one-cycle arr_wr_en into the PLRU victim way
// RESP   | one-cycle rsp_valid
// FLUSH  | invalidate sets 0..NSET-1, clearing their PLRU rows
module stlb_ctrl #(
  parameter int NSET  = 16,
  parameter int NWAY  = 4,
  parameter int SVPN  = 52,
  parameter int SPCID = 12,
  localparam int SW = $clog2(NSET),
  localparam int WW = $clog2(NWAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SVPN-1:0]  req_vpn,
  input  logic [SPCID-1:0] req_pcid,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WW-1:0]    rsp_way,
  output logic             arr_rd_en,
  output logic [SW-1:0]    arr_set,
  output logic [SVPN-1:0]  arr_vpn,
  output logic [SPCID-1:0] arr_pcid,
  input  logic [NWAY-1:0]  arr_hit,
  output logic             arr_wr_en,
  output logic [WW-1:0]    arr_wr_way,
  output logic             arr_inv,
  output logic             walk_req_valid,
  input  logic             walk_req_ready,
  input  logic             walk_rsp_valid,
  input  logic             flush,
  output logic             flush_busy
);

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, RESP, WALK, WAIT, FILL, FLUSH} state_t;

  state_t                    state_q, state_d;
  logic [NSET-1:0][NWAY-2:0] plru_q, plru_d;
  logic [SW-1:0]             cnt_q, cnt_d;
  logic                      flush_pending_q, flush_pending_d;
  logic                      req_ready_q, req_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_hit_q, rsp_hit_d;
  logic [WW-1:0]             rsp_way_q, rsp_way_d;
  logic                      arr_rd_en_q, arr_rd_en_d;
  logic [SW-1:0]             arr_set_q, arr_set_d;
  logic [SVPN-1:0]           arr_vpn_q, arr_vpn_d;
  logic [SPCID-1:0]          arr_pcid_q, arr_pcid_d;
  logic                      arr_wr_en_q, arr_wr_en_d;
  logic [WW-1:0]             arr_wr_way_q, arr_wr_way_d;
  logic                      arr_inv_q, arr_inv_d;
  logic                      walk_req_valid_q, walk_req_valid_d;
  logic                      flush_busy_q, flush_busy_d;
  logic [WW-1:0]             hit_way;

  function automatic logic [WW-1:0] first_hit(input logic [NWAY-1:0] v);
    logic [WW-1:0] w;
    w = '0;
    for (int j = NWAY - 1; j >= 0; j--) if (v[j]) w = WW'(j);
    return w;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  function automatic logic [WW-1:0] plru_victim(input logic [NWAY-2:0] row);
    int   node;
    logic b;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      b = 1'b0;
      for (int j = 0; j < NWAY - 1; j++) if (j == node) b = row[j];
      node = 2 * node + (b ? 2 : 1);
    end
    return WW'(node - (NWAY - 1));
  endfunction

  function automatic logic [NWAY-2:0] plru_touch(input logic [NWAY-2:0] row,
                                                 input logic [WW-1:0]   way);
    logic [NWAY-2:0] r;
    logic [WW-1:0]   w;
    int              node;
    logic            b;
    r = row;
    w = way;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      b = w[WW-1];
      w = w << 1;
      for (int j = 0; j < NWAY - 1; j++) if (j == node) r[j] = ~b;
      node = 2 * node + (b ? 2 : 1);
    end
    return r;
  endfunction

  assign hit_way = first_hit(arr_hit);

  always_comb begin
    state_d          = state_q;
    plru_d           = plru_q;
    cnt_d            = cnt_q;
    flush_pending_d  = flush_pending_q | flush;
    req_ready_d      = 1'b0;
    rsp_valid_d      = 1'b0;
    rsp_hit_d        = rsp_hit_q;
    rsp_way_d        = rsp_way_q;
    arr_rd_en_d      = 1'b0;
    arr_set_d        = arr_set_q;
    arr_vpn_d        = arr_vpn_q;
    arr_pcid_d       = arr_pcid_q;
    arr_wr_en_d      = 1'b0;
    arr_wr_way_d     = arr_wr_way_q;
    arr_inv_d        = 1'b0;
    walk_req_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_pending_q) begin
          // a flush arriving this same cycle is covered by the sweep starting now
          state_d         = FLUSH;
          flush_pending_d = 1'b0;
          cnt_d           = '0;
          arr_set_d       = '0;
          arr_inv_d       = 1'b1;
        end else if (req_valid && req_ready_q) begin
          state_d     = LOOKUP;
          arr_rd_en_d = 1'b1;
          arr_set_d   = req_vpn[SW-1:0];
          arr_vpn_d   = req_vpn;
          arr_pcid_d  = req_pcid;
        end else begin
          req_ready_d = !flush_pending_d;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (|arr_hit) begin
          plru_d[arr_set_q] = plru_touch(plru_q[arr_set_q], hit_way);
          rsp_hit_d         = 1'b1;
          rsp_way_d         = hit_way;
          rsp_valid_d       = 1'b1;
          state_d           = RESP;
        end else begin
          arr_wr_way_d     = plru_victim(plru_q[arr_set_q]);
          walk_req_valid_d = 1'b1;
          state_d          = WALK;
        end
      end
      WALK: begin
        if (walk_req_ready) state_d = WAIT;
        else walk_req_valid_d = 1'b1;
      end
      WAIT: begin
        if (walk_rsp_valid) begin
          state_d     = FILL;
          arr_wr_en_d = 1'b1;
        end
      end
      FILL: begin
        plru_d[arr_set_q] = plru_touch(plru_q[arr_set_q], arr_wr_way_q);
        rsp_hit_d         = 1'b0;
        rsp_way_d         = arr_wr_way_q;
        rsp_valid_d       = 1'b1;
        state_d           = RESP;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = !flush_pending_d;
      end
      FLUSH: begin
        plru_d[cnt_q] = '0;
        if (cnt_q == SW'(NSET - 1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          req_ready_d = !flush_pending_d;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          arr_set_d = cnt_q + 1'b1;
          arr_inv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    flush_busy_d = flush_pending_d || (state_d == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      plru_q           <= '0;
      cnt_q            <= '0;
      flush_pending_q  <= 1'b0;
      req_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      rsp_hit_q        <= 1'b0;
      rsp_way_q        <= '0;
      arr_rd_en_q      <= 1'b0;
      arr_set_q        <= '0;
      arr_vpn_q        <= '0;
      arr_pcid_q       <= '0;
      arr_wr_en_q      <= 1'b0;
      arr_wr_way_q     <= '0;
      arr_inv_q        <= 1'b0;
      walk_req_valid_q <= 1'b0;
      flush_busy_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      plru_q           <= plru_d;
      cnt_q            <= cnt_d;
      flush_pending_q  <= flush_pending_d;
      req_ready_q      <= req_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_hit_q        <= rsp_hit_d;
      rsp_way_q        <= rsp_way_d;
      arr_rd_en_q      <= arr_rd_en_d;
      arr_set_q        <= arr_set_d;
      arr_vpn_q        <= arr_vpn_d;
      arr_pcid_q       <= arr_pcid_d;
      arr_wr_en_q      <= arr_wr_en_d;
      arr_wr_way_q     <= arr_wr_way_d;
      arr_inv_q        <= arr_inv_d;
      walk_req_valid_q <= walk_req_valid_d;
      flush_busy_q     <= flush_busy_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_hit        = rsp_hit_q;
  assign rsp_way        = rsp_way_q;
  assign arr_rd_en      = arr_rd_en_q;
  assign arr_set        = arr_set_q;
  assign arr_vpn        = arr_vpn_q;
  assign arr_pcid       = arr_pcid_q;
  assign arr_wr_en      = arr_wr_en_q;
  assign arr_wr_way     = arr_wr_way_q;
  assign arr_inv        = arr_inv_q;
  assign walk_req_valid = walk_req_valid_q;
  assign flush_busy     = flush_busy_q;

endmodule

// File: tb/tb_stlb_ctrl.sv
// Bench for stlb_ctrl: directed and randomized lookups checked against an
// interval-halving tree-PLRU model kept in the bench.
module tb_stlb_ctrl;
  localparam int NSET  = 16;
  localparam int NWAY  = 4;
  localparam int SVPN  = 52;
  localparam int SPCID = 12;
  localparam int SW    = $clog2(NSET);
  localparam int WW    = $clog2(NWAY);

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [SVPN-1:0]  req_vpn;
  logic [SPCID-1:0] req_pcid;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WW-1:0]    rsp_way;
  logic             arr_rd_en;
  logic [SW-1:0]    arr_set;
  logic [SVPN-1:0]  arr_vpn;
  logic [SPCID-1:0] arr_pcid;
  logic [NWAY-1:0]  arr_hit;
  logic             arr_wr_en;
  logic [WW-1:0]    arr_wr_way;
  logic             arr_inv;
  logic             walk_req_valid;
  logic             walk_req_ready;
  logic             walk_rsp_valid;
  logic             flush;
  logic             flush_busy;

  int checks   = 0;
  int failures = 0;
  int mplru [NSET][NWAY-1];

  stlb_ctrl #(.NSET(NSET), .NWAY(NWAY), .SVPN(SVPN), .SPCID(SPCID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .req_pcid(req_pcid),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .arr_rd_en(arr_rd_en), .arr_set(arr_set), .arr_vpn(arr_vpn), .arr_pcid(arr_pcid),
    .arr_hit(arr_hit), .arr_wr_en(arr_wr_en), .arr_wr_way(arr_wr_way), .arr_inv(arr_inv),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
    .walk_rsp_valid(walk_rsp_valid), .flush(flush), .flush_busy(flush_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Each tree node covers an interval of ways; bit 1 sends the walk to the upper half.
  function automatic int m_victim(int s);
    int node = 0;
    int lo = 0;
    int hi = NWAY;
    while (hi - lo > 1) begin
      if (mplru[s][node] != 0) begin lo = (lo + hi) / 2; node = 2 * node + 2; end
      else begin hi = (lo + hi) / 2; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  function automatic void m_touch(int s, int w);
    int node = 0;
    int lo = 0;
    int hi = NWAY;
    int mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin mplru[s][node] = 1; hi = mid; node = 2 * node + 1; end
      else begin mplru[s][node] = 0; lo = mid; node = 2 * node + 2; end
    end
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < NSET; s++)
      for (int n = 0; n < NWAY - 1; n++) mplru[s][n] = 0;
  endfunction

  function automatic logic [SVPN-1:0] vpn_for_set(int s);
    logic [SVPN-1:0] v;
    v = SVPN'({$urandom(), $urandom()});
    v[SW-1:0] = SW'(s);
    return v;
  endfunction

  task automatic do_lookup(input logic [SVPN-1:0] vpn, input logic [NWAY-1:0] hv,
                           input int rdy_dly, input int rsp_dly, input bit overlap,
                           input bit flush_wait, output int got_way);
    int s;
    int exp_way;
    logic [SPCID-1:0] pcid;
    s = int'(vpn[SW-1:0]);
    pcid = SPCID'($urandom());
    got_way = -1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_vpn = vpn; req_pcid = pcid;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (arr_rd_en !== 1'b1 || arr_set !== SW'(s) || arr_vpn !== vpn || arr_pcid !== pcid || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL lookup_strobe: got rd_en=%b set=%0d vpn=%0h pcid=%0h ready=%b expected 1 %0d %0h %0h 0",
               arr_rd_en, arr_set, arr_vpn, arr_pcid, req_ready, s, vpn, pcid);
    end
    arr_hit = hv;
    @(negedge clk);
    checks++;
    if (arr_rd_en !== 1'b0) begin
      failures++; $display("FAIL rd_en_one_cycle: got %b expected 0", arr_rd_en);
    end
    @(negedge clk);
    arr_hit = '0;
    if (hv != '0) begin
      exp_way = -1;
      for (int j = 0; j < NWAY; j++) if (hv[j] && exp_way < 0) exp_way = j;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_way !== WW'(exp_way) || walk_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL hit_rsp: got valid=%b hit=%b way=%0d walk=%b expected 1 1 %0d 0",
                 rsp_valid, rsp_hit, rsp_way, walk_req_valid, exp_way);
      end
      got_way = int'(rsp_way);
      m_touch(s, exp_way);
    end else begin
      exp_way = m_victim(s);
      checks++;
      if (walk_req_valid !== 1'b1 || rsp_valid !== 1'b0) begin
        failures++; $display("FAIL walk_start: got walk=%b rsp=%b expected 1 0", walk_req_valid, rsp_valid);
      end
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk);
        checks++;
        if (walk_req_valid !== 1'b1) begin
          failures++; $display("FAIL walk_hold: got %b expected 1", walk_req_valid);
        end
      end
      walk_req_ready = 1'b1; walk_rsp_valid = overlap;
      @(negedge clk);
      walk_req_ready = 1'b0; walk_rsp_valid = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
        checks++;
        if (walk_req_valid !== 1'b0 || arr_wr_en !== 1'b0 || rsp_valid !== 1'b0) begin
          failures++;
          $display("FAIL wait_quiet: got walk=%b wr_en=%b rsp=%b expected 0 0 0", walk_req_valid, arr_wr_en, rsp_valid);
        end
        if (i == 0 && flush_wait) flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (i == 0 && flush_wait) begin
          checks++;
          if (flush_busy !== 1'b1) begin
            failures++; $display("FAIL flush_busy_rise: got %b expected 1", flush_busy);
          end
        end
      end
      walk_rsp_valid = 1'b1;
      @(negedge clk);
      walk_rsp_valid = 1'b0;
      checks++;
      if (arr_wr_en !== 1'b1 || arr_wr_way !== WW'(exp_way) || arr_set !== SW'(s) || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL fill: got wr_en=%b way=%0d set=%0d rsp=%b expected 1 %0d %0d 0",
                 arr_wr_en, arr_wr_way, arr_set, rsp_valid, exp_way, s);
      end
      @(negedge clk);
      checks++;
      if (arr_wr_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_way !== WW'(exp_way)) begin
        failures++;
        $display("FAIL miss_rsp: got wr_en=%b valid=%b hit=%b way=%0d expected 0 1 0 %0d",
                 arr_wr_en, rsp_valid, rsp_hit, rsp_way, exp_way);
      end
      got_way = int'(rsp_way);
      m_touch(s, exp_way);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rsp_pulse: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic check_sweep();
    int waited = 0;
    while (arr_inv !== 1'b1 && waited < 4) begin
      checks++;
      if (req_ready !== 1'b0) begin
        failures++; $display("FAIL ready_while_pending: got %b expected 0", req_ready);
      end
      @(negedge clk);
      waited++;
    end
    checks++;
    if (arr_inv !== 1'b1) begin
      failures++; $display("FAIL sweep_start: got arr_inv=%b expected 1 within 4 cycles", arr_inv);
    end else begin
      for (int i = 0; i < NSET; i++) begin
        checks++;
        if (arr_inv !== 1'b1 || arr_set !== SW'(i) || req_ready !== 1'b0 || flush_busy !== 1'b1) begin
          failures++;
          $display("FAIL sweep_cycle_%0d: got inv=%b set=%0d ready=%b busy=%b expected 1 %0d 0 1",
                   i, arr_inv, arr_set, req_ready, flush_busy, i);
        end
        @(negedge clk);
      end
      checks++;
      if (arr_inv !== 1'b0 || flush_busy !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL sweep_end: got inv=%b busy=%b ready=%b expected 0 0 1", arr_inv, flush_busy, req_ready);
      end
    end
    m_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_hit, arr_rd_en, arr_wr_en, arr_inv, walk_req_valid, flush_busy} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 10000000",
               {req_ready, rsp_valid, rsp_hit, arr_rd_en, arr_wr_en, arr_inv, walk_req_valid, flush_busy});
    end
    checks++;
    if (rsp_way !== '0 || arr_set !== '0 || arr_wr_way !== '0 || arr_vpn !== '0 || arr_pcid !== '0) begin
      failures++;
      $display("FAIL reset_data: got way=%0h set=%0h wr_way=%0h vpn=%0h pcid=%0h expected all 0",
               rsp_way, arr_set, arr_wr_way, arr_vpn, arr_pcid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    m_clear();
  endtask

  task automatic test_hit();
    int w;
    do_lookup(SVPN'(5), 4'b0100, 0, 1, 1'b0, 1'b0, w);
    checks++;
    if (w != 2) begin failures++; $display("FAIL hit_way2: got %0d expected 2", w); end
    // set 5 tree now points to ways 0 and then 3
    do_lookup(vpn_for_set(5), '0, 0, 1, 1'b0, 1'b0, w);
    checks++;
    if (w != 0) begin failures++; $display("FAIL hit_then_miss_a: got %0d expected 0", w); end
    do_lookup(vpn_for_set(5), '0, 1, 2, 1'b0, 1'b0, w);
    checks++;
    if (w != 3) begin failures++; $display("FAIL hit_then_miss_b: got %0d expected 3", w); end
  endtask

  task automatic test_victim_seq();
    int w;
    int exp_seq [3] = '{0, 2, 1};
    for (int k = 0; k < 3; k++) begin
      do_lookup(vpn_for_set(3), '0, 2, 5, 1'b0, 1'b0, w);
      checks++;
      if (w != exp_seq[k]) begin
        failures++; $display("FAIL victim_seq_%0d: got %0d expected %0d", k, w, exp_seq[k]);
      end
    end
  endtask

  task automatic test_multi_hit();
    int w;
    do_lookup(vpn_for_set(7), 4'b1010, 0, 1, 1'b0, 1'b0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL multi_hit: got %0d expected 1", w); end
  endtask

  task automatic test_flush_in_wait();
    int w;
    do_lookup(vpn_for_set(3), '0, 1, 3, 1'b0, 1'b1, w);
    checks++;
    if (w != 3) begin failures++; $display("FAIL flush_wait_fill: got %0d expected 3", w); end
    check_sweep();
    do_lookup(vpn_for_set(3), '0, 0, 2, 1'b0, 1'b0, w);
    checks++;
    if (w != 0) begin failures++; $display("FAIL post_flush_fill: got %0d expected 0", w); end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (flush_busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL flush_idle_capture: got busy=%b ready=%b expected 1 0", flush_busy, req_ready);
    end
    check_sweep();
  endtask

  task automatic test_reset_in_walk();
    req_valid = 1'b1; req_vpn = vpn_for_set(9); req_pcid = '0;
    @(negedge clk);
    req_valid = 1'b0; arr_hit = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (walk_req_valid !== 1'b1) begin
      failures++; $display("FAIL reset_walk_setup: got %b expected 1", walk_req_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (walk_req_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || flush_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got walk=%b ready=%b rsp=%b busy=%b expected 0 1 0 0",
               walk_req_valid, req_ready, rsp_valid, flush_busy);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || walk_req_valid !== 1'b0) begin
        failures++; $display("FAIL reset_hold: got rsp=%b walk=%b expected 0 0", rsp_valid, walk_req_valid);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_walk_release: got ready=%b rsp=%b expected 1 0", req_ready, rsp_valid);
    end
    m_clear();
  endtask

  task automatic test_random_back_to_back();
    int w;
    logic [NWAY-1:0] hv;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1, 0) == 0) hv = '0;
      else hv = NWAY'($urandom_range((1 << NWAY) - 1, 1));
      do_lookup(vpn_for_set(int'($urandom_range(NSET - 1, 0))), hv,
                int'($urandom_range(3, 0)), int'($urandom_range(5, 1)),
                bit'($urandom_range(1, 0)), 1'b0, w);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_vpn = '0; req_pcid = '0; arr_hit = '0;
    walk_req_ready = 1'b0; walk_rsp_valid = 1'b0; flush = 1'b0;
    test_reset();
    test_hit();
    test_victim_seq();
    test_multi_hit();
    test_flush_in_wait();
    test_flush_idle();
    test_reset_in_walk();
    test_random_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
